// File: rtl/keypoint_reader.sv
// keypoint_reader: streams keypoints out of a 2-cycle-latency BRAM through a 4-entry FIFO; define KEYPOINT_READER_BORDER_FILTER_EN to drop image-border points.
module keypoint_reader #(
  parameter int DIMENSION = 64,
  parameter int NUMBER_KEYPOINTS = 1000,
  localparam int W = $clog2(DIMENSION),
  localparam int A = $clog2(NUMBER_KEYPOINTS)
) (
  input  logic           clk,
  input  logic           rst_in,
  input  logic           start,
  input  logic [A-1:0]   key_count,
  output logic [A-1:0]   key_read_addr,
  input  logic [2*W:0]   key_read_data,
  output logic [W-1:0]   kp_x,
  output logic [W-1:0]   kp_y,
  output logic           kp_flag,
  output logic           kp_valid,
  input  logic           kp_ready,
  output logic           busy,
  output logic           done
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_n;
  logic [A:0] count_q, issued_q, issued_n, kc;
  logic [A-1:0] addr_q;
  logic [1:0] v, in_flight, wp, rp;
  logic [2:0] occ;
  logic [2*W:0] mem [4];
  logic [2*W:0] head;
  logic issue, push, pop, border, drained;
`ifdef KEYPOINT_READER_BORDER_FILTER_EN
  assign border = key_read_data[W-1:0] == '0 || key_read_data[2*W-1:W] == '0 ||
                  key_read_data[W-1:0] == W'(DIMENSION - 1) || key_read_data[2*W-1:W] == W'(DIMENSION - 1);
`else
  assign border = 1'b0;
`endif
  // The first read goes out in the start cycle itself so the first keypoint appears 3 cycles later.
  always_comb begin
    kc = ({1'b0, key_count} > (A+1)'(NUMBER_KEYPOINTS)) ? (A+1)'(NUMBER_KEYPOINTS) : {1'b0, key_count};
    in_flight = {1'b0, v[0]} + {1'b0, v[1]};
    issue = !rst_in && ((state == IDLE && start && kc != '0) ||
            (state == FETCH && issued_q < count_q && 4'(occ) + 4'(in_flight) < 4'd4));
    issued_n = (state == IDLE) ? (A+1)'(issue) : issued_q + (A+1)'(issue);
    key_read_addr = issue ? ((state == IDLE) ? '0 : issued_q[A-1:0]) : addr_q;
    drained = in_flight == 2'd0 && occ == 3'd0;
    state_n = (state == IDLE && start) ? ((kc <= (A+1)'(1)) ? DRAIN : FETCH) :
              (state == FETCH && issued_n == count_q) ? DRAIN :
              (state == DRAIN && drained) ? IDLE : state;
    done = !rst_in && state == DRAIN && drained;
    busy = state != IDLE;
    push = v[1] && !border;
    kp_valid = occ != 3'd0;
    pop = kp_valid && kp_ready;
    head = mem[rp];
    kp_x = head[W-1:0];
    kp_y = head[2*W-1:W];
    kp_flag = head[2*W];
  end
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= IDLE;
      addr_q <= '0;
      count_q <= '0;
      issued_q <= '0;
      v <= '0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else begin
      state <= state_n;
      addr_q <= key_read_addr;
      issued_q <= issued_n;
      v <= {v[0], issue};
      if (state == IDLE && start) count_q <= kc;
      if (push) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      occ <= occ + 3'(push) - 3'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= key_read_data;
endmodule

// File: doc/keypoint_reader.md
KEYPOINT_READER -- requirements
Module: keypoint_reader

Interface
REQ-001 SHALL have parameter DIMENSION, default 64: image side in pixels; W = $clog2(DIMENSION).
REQ-002 SHALL have parameter NUMBER_KEYPOINTS, default 1000: keypoint BRAM depth; A = $clog2(NUMBER_KEYPOINTS).
REQ-003 SHALL have ports: clk input 1, the single clock; rst_in input 1, reset, synchronous, active-high.
REQ-004 SHALL have ports: start input 1, one-cycle pulse that begins a readout; key_count input A, number of valid entries, equal to the writer's final write address.
REQ-005 SHALL have ports: key_read_addr output A, BRAM read address; key_read_data input 2W+1, BRAM read data.
REQ-006 SHALL have ports: kp_x output W; kp_y output W; kp_flag output 1; kp_valid output 1; kp_ready input 1.
REQ-007 SHALL have ports: busy output 1, readout in progress; done output 1, one-cycle completion pulse.

Function
REQ-008 SHALL decode each BRAM word as: bits [W-1:0] = x, bits [2W-1:W] = y, bit [2W] = flag.
REQ-009 SHALL treat BRAM read latency as exactly 2 cycles: data for the address presented in cycle n is valid at cycle n+2.
REQ-010 SHALL implement the FSM IDLE -> FETCH -> DRAIN -> IDLE.
REQ-011 In IDLE with start=1, SHALL latch key_count (clamped to NUMBER_KEYPOINTS), zero the issue counter and enter FETCH.
REQ-012 In FETCH, SHALL issue one read per cycle while (issued < count) and (fifo_occupancy + in_flight < 4).
REQ-013 SHALL track in-flight reads with a 2-stage valid shift register aligned to BRAM latency, and SHALL push returned words into a 4-entry output FIFO.
REQ-014 SHALL enter DRAIN when issued == count, and SHALL return to IDLE when in_flight == 0 and the FIFO is empty, pulsing done for exactly 1 cycle on that transition.
REQ-015 kp_valid SHALL equal FIFO non-empty; kp_x, kp_y and kp_flag SHALL present the FIFO head.
REQ-016 A pop SHALL occur when kp_valid && kp_ready; output fields SHALL hold stable while kp_valid=1 and kp_ready=0.
REQ-017 With kp_ready held at 1, throughput SHALL be 1 keypoint per cycle after an initial latency of 3 cycles from start to first kp_valid.
REQ-018 A push and a pop in the same cycle SHALL leave occupancy unchanged; the FIFO SHALL never overflow.
REQ-019 Keypoints SHALL be emitted in address order 0..count-1, each exactly once.
REQ-020 When key_count == 0, no read SHALL be issued, and done SHALL pulse in the cycle after start.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 busy SHALL be 1 in FETCH and DRAIN, and 0 in IDLE.
REQ-023 key_read_addr SHALL hold its last value when no read is issued.

Reset
REQ-024 rst_in=1 SHALL force: state IDLE; key_read_addr=0; kp_valid=0; done=0; busy=0; FIFO empty; in-flight cleared; issue counter and latched count 0.
REQ-025 Reset asserted mid-readout SHALL discard all in-flight and buffered keypoints; no kp_valid or done SHALL follow until a new start.

Configuration
REQ-026 Macro KEYPOINT_READER_BORDER_FILTER_EN, when defined, SHALL drop returned words where x==0, y==0, x==DIMENSION-1 or y==DIMENSION-1. Dropped words are never pushed to the FIFO but still count as completed reads.
REQ-027 Without KEYPOINT_READER_BORDER_FILTER_EN, every returned word SHALL be emitted.

Verification
REQ-028 BRAM preloaded 0..4 with {flag,y,x} = (0,1,1),(1,2,3),(0,5,9),(1,62,7),(0,10,10); key_count=5; kp_ready=1; pulse start -> 5 outputs in order, first kp_valid 3 cycles after start, consecutive cycles, done 1 cycle after last pop.
REQ-029 Same preload; kp_ready toggled 1,0,0,1 repeating -> identical 5-word sequence, no duplicates or drops, outputs stable while stalled, done only after 5th pop.
REQ-030 key_count=0; pulse start -> no key_read_addr change, kp_valid never 1, done high exactly the cycle after start.
REQ-031 key_count=1000; kp_ready=0 for 20 cycles -> at most 4 reads issued, then release -> all 1000 emitted in order, FIFO never exceeds 4.
REQ-032 rst_in pulsed 1 cycle after 3rd output, then new start with key_count=2 -> only entries 0 and 1 emitted, no stale data.
REQ-033 With KEYPOINT_READER_BORDER_FILTER_EN defined, REQ-028 preload (entry 3 edited to x=0) -> only entries 0,1,2,4 emitted; done still pulses.
